pgm_boot_loader: RTL and testbench

// - Upstream boot stage for the core: receives a program as 16-bit halfwords over a valid/ready stream,

---
 rtl/pgm_boot_pkg.sv | 37 +++
 rtl/boot_csum.sv | 23 ++
 rtl/pgm_boot_loader.sv | 111 +++++++++++
 tb/tb_pgm_boot_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pgm_boot_pkg.sv
// Shared definitions for the program boot loader and the core it feeds.
// Holds the loader state encoding, the memory and stream geometry, and the
// instruction field positions the core decodes.
package pgm_boot_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 32;
  localparam int DW    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_WR,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } boot_state_t;

  // Instruction field positions, shared with the core decoder
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // A header is usable only if it names between one and DEPTH instructions
  function automatic logic hdr_ok(input logic [DW-1:0] n);
    return (n != '0) && (n <= DW'(DEPTH));
  endfunction

endpackage

// File: rtl/boot_csum.sv
// Running 16-bit checksum of the accepted stream words.
// Used by pgm_boot_loader only when BOOT_CHECKSUM_EN is defined.
module boot_csum
  import pgm_boot_pkg::*;
(
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          clear,
  input  logic          add_en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] sum
);

  // Accumulate modulo 2^16; clear wins so a new session always starts from zero
  always_ff @(posedge clk) begin
    if (sys_rst || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/pgm_boot_loader.sv
// Boot loader: receives a header, then hi/lo halfword pairs, writes each
// assembled instruction into program memory and finally releases the core.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailer checksum word.
module pgm_boot_loader
  import pgm_boot_pkg::*;
(
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start_load,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          pm_we,
  output logic [AW-1:0] pm_addr,
  output logic [IW-1:0] pm_wdata,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err
);

  boot_state_t   state;
  boot_state_t   state_nxt;
  logic [AW-1:0] cnt;
  logic [AW:0]   n_instr;
  logic [DW-1:0] hi_word;
  logic [DW-1:0] lo_word;
  logic          accept;
  logic          last_wr;
  logic          wr_active;

  assign accept    = in_valid && in_ready;
  assign last_wr   = ((AW+1)'(cnt) + (AW+1)'(1)) == n_instr;
  assign wr_active = (state == ST_WR) && !sys_rst;

`ifdef BOOT_CHECKSUM_EN
  logic [DW-1:0] csum;
  logic          csum_clear;
  logic          csum_add;

  assign csum_clear = (state_nxt == ST_HDR) && (state != ST_HDR);
  assign csum_add   = accept && ((state == ST_HDR) || (state == ST_HI) || (state == ST_LO));

  boot_csum u_csum (
    .clk     (clk),
    .sys_rst (sys_rst),
    .clear   (csum_clear),
    .add_en  (csum_add),
    .data    (in_data),
    .sum     (csum)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a session in progress ignores start_load
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_load) state_nxt = ST_HDR;
      ST_HDR:  if (accept) state_nxt = hdr_ok(in_data) ? ST_HI : ST_ERR;
      ST_HI:   if (accept) state_nxt = ST_LO;
      ST_LO:   if (accept) state_nxt = ST_WR;
`ifdef BOOT_CHECKSUM_EN
      ST_WR:   state_nxt = last_wr ? ST_CHK : ST_HI;
      ST_CHK:  if (accept) state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
`else
      ST_WR:   state_nxt = last_wr ? ST_DONE : ST_HI;
`endif
      ST_DONE: if (start_load) state_nxt = ST_HDR;
      ST_ERR:  if (start_load) state_nxt = ST_HDR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction count, write index and halfword holding registers
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt     <= '0;
      n_instr <= '0;
      hi_word <= '0;
      lo_word <= '0;
    end else begin
      if ((state == ST_HDR) && accept && hdr_ok(in_data)) begin
        n_instr <= in_data[AW:0];
        cnt     <= '0;
      end
      if ((state == ST_HI) && accept) hi_word <= in_data;
      if ((state == ST_LO) && accept) lo_word <= in_data;
      if (state == ST_WR) cnt <= cnt + 1'b1;
    end
  end

  // Output decode from the registered state; the write strobe is held off in a reset cycle
  always_comb begin
    in_ready  = (state == ST_HDR) || (state == ST_HI) || (state == ST_LO) || (state == ST_CHK);
    pm_we     = wr_active;
    pm_addr   = wr_active ? cnt : '0;
    pm_wdata  = wr_active ? {hi_word, lo_word} : '0;
    core_rst  = (state != ST_DONE);
    load_done = (state == ST_DONE);
    load_err  = (state == ST_ERR);
  end

endmodule

// File: tb/tb_pgm_boot_loader.sv
// Directed self-checking bench for pgm_boot_loader (checksum feature via BOOT_CHECKSUM_EN).
module tb_pgm_boot_loader;
  import pgm_boot_pkg::*;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start_load;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [IW-1:0] pm_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int fails  = 0;

  logic [AW-1:0] wr_addr_q [$];
  logic [IW-1:0] wr_data_q [$];
  logic [IW-1:0] mem  [DEPTH];
  logic [IW-1:0] prog [DEPTH];

  pgm_boot_loader dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start_load (start_load),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Record every program memory write and keep a copy of memory contents
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_wdata);
      mem[pm_addr] = pm_wdata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pulseStart();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  // Offer one word and return at the negedge after it has been taken
  task automatic sendWord(input logic [DW-1:0] w, input bit gaps);
    int budget;
    if (gaps && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  // Full session from prog[0..n-1], trailer computed when the checksum is built in
  task automatic applyStimulus(input int n, input bit gaps);
    logic [DW-1:0] sum;
    int budget;
    pulseStart();
    sum = DW'(n);
    sendWord(DW'(n), gaps);
    for (int i = 0; i < n; i++) begin
      sendWord(prog[i][31:16], gaps);
      sendWord(prog[i][15:0], gaps);
      sum = sum + prog[i][31:16] + prog[i][15:0];
    end
`ifdef BOOT_CHECKSUM_EN
    sendWord(sum, gaps);
`endif
    in_valid = 1'b0;
    budget = 0;
    while (!load_done && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("load_done", {31'd0, load_done}, 32'd1);
    checkOutput("core_rst_released", {31'd0, core_rst}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    checkOutput({tag, "_pm_we"},     {31'd0, pm_we},     32'd0);
    checkOutput({tag, "_pm_addr"},   {28'd0, pm_addr},   32'd0);
    checkOutput({tag, "_pm_wdata"},  pm_wdata,           32'd0);
    checkOutput({tag, "_core_rst"},  {31'd0, core_rst},  32'd1);
    checkOutput({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    checkOutput({tag, "_load_err"},  {31'd0, load_err},  32'd0);
  endtask

  initial begin
    sys_rst    = 1'b1;
    start_load = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    sys_rst = 1'b0;
    @(negedge clk);

    // Nominal two-instruction load with in_valid held high
    $display("[TB] nominal load");
    wr_addr_q.delete(); wr_data_q.delete();
    pulseStart();
    checkOutput("hdr_ready", {31'd0, in_ready}, 32'd1);
    sendWord(16'd2, 1'b0);
    sendWord(16'h0841, 1'b0);
    sendWord(16'h0005, 1'b0);
    checkOutput("wr0_we",    {31'd0, pm_we},   32'd1);
    checkOutput("wr0_addr",  {28'd0, pm_addr}, 32'd0);
    checkOutput("wr0_data",  pm_wdata,         32'h08410005);
    checkOutput("wr0_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("wr0_core_rst", {31'd0, core_rst}, 32'd1);
    sendWord(16'h1088, 1'b0);
    sendWord(16'h0003, 1'b0);
    checkOutput("wr1_we",   {31'd0, pm_we},   32'd1);
    checkOutput("wr1_addr", {28'd0, pm_addr}, 32'd1);
    checkOutput("wr1_data", pm_wdata,         32'h10880003);
`ifdef BOOT_CHECKSUM_EN
    sendWord(16'h18D3, 1'b0);
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
    @(negedge clk);
`endif
    checkOutput("nom_core_rst",  {31'd0, core_rst},  32'd0);
    checkOutput("nom_load_done", {31'd0, load_done}, 32'd1);
    checkOutput("nom_writes", wr_addr_q.size(), 32'd2);

    // Reload from DONE raises core_rst at once, then bad headers
    $display("[TB] reload and bad headers");
    wr_addr_q.delete(); wr_data_q.delete();
    pulseStart();
    checkOutput("reload_core_rst",  {31'd0, core_rst},  32'd1);
    checkOutput("reload_load_done", {31'd0, load_done}, 32'd0);
    sendWord(16'd0, 1'b0);
    in_valid = 1'b0;
    checkOutput("n0_load_err", {31'd0, load_err}, 32'd1);
    checkOutput("n0_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("n0_ready",    {31'd0, in_ready}, 32'd0);
    pulseStart();
    checkOutput("restart_clears_err", {31'd0, load_err}, 32'd0);
    sendWord(16'd17, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("n17_load_err", {31'd0, load_err}, 32'd1);
    checkOutput("n17_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("bad_hdr_writes", wr_addr_q.size(), 32'd0);

    // Full-depth load with random gaps on in_valid
    $display("[TB] backpressure full-depth load");
    for (int i = 0; i < DEPTH; i++) prog[i] = {16'h1000 + 16'(i) * 16'h0111, 16'hA000 + 16'(i)};
    wr_addr_q.delete(); wr_data_q.delete();
    applyStimulus(DEPTH, 1'b1);
    checkOutput("bp_writes", wr_addr_q.size(), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("bp_addr", {28'd0, wr_addr_q[i]}, 32'(i));
      checkOutput("bp_data", wr_data_q[i], {16'h1000 + 16'(i) * 16'h0111, 16'hA000 + 16'(i)});
    end

    // sys_rst after the hi word of instruction 3
    $display("[TB] reset during load");
    for (int i = 0; i < DEPTH; i++) prog[i] = {16'h2000 + 16'(i), 16'h0B00 + 16'(i)};
    wr_addr_q.delete(); wr_data_q.delete();
    pulseStart();
    sendWord(16'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sendWord(prog[i][31:16], 1'b0);
      sendWord(prog[i][15:0], 1'b0);
    end
    sendWord(prog[3][31:16], 1'b0);
    sys_rst = 1'b1;
    checkOutput("rst_cycle_we", {31'd0, pm_we}, 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    checkResetValues("midload");
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midload_writes", wr_addr_q.size(), 32'd3);
    checkOutput("midload_idle_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("mem3_kept", mem[3], {16'h1333, 16'hA003});

    // Following full load succeeds and overwrites only entries 0..N-1
    for (int i = 0; i < DEPTH; i++) prog[i] = {16'h3000 + 16'(i), 16'h0C00 + 16'(i)};
    applyStimulus(3, 1'b0);
    checkOutput("mem0_new", mem[0], 32'h30000C00);
    checkOutput("mem2_new", mem[2], 32'h30020C02);
    checkOutput("mem3_old", mem[3], 32'h1333A003);
    checkOutput("mem15_old", mem[15], {16'h1000 + 16'hFFF, 16'hA00F});

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] checksum trailer");
    pulseStart();
    sendWord(16'd1, 1'b0);
    sendWord(16'hC800, 1'b0);
    sendWord(16'h0000, 1'b0);
    sendWord(16'hC801, 1'b0);
    in_valid = 1'b0;
    checkOutput("csum_ok_done",     {31'd0, load_done}, 32'd1);
    checkOutput("csum_ok_core_rst", {31'd0, core_rst},  32'd0);
    pulseStart();
    sendWord(16'd1, 1'b0);
    sendWord(16'hC800, 1'b0);
    sendWord(16'h0000, 1'b0);
    sendWord(16'hC802, 1'b0);
    in_valid = 1'b0;
    checkOutput("csum_bad_err",      {31'd0, load_err},  32'd1);
    checkOutput("csum_bad_core_rst", {31'd0, core_rst},  32'd1);
    checkOutput("csum_bad_done",     {31'd0, load_done}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
